run_length_fsm: RTL and testbench
=================================

Name: run_length_fsm

Overview:
- Parametrised successor to the team's 3-bit single-input state machine.
- Measures the length of consecutive-high runs on in_i. Reports a live count, a one-cycle threshold-hit pulse and the final run length on a valid strobe.
- Supports saturate or wrap counting and a synchronous clear.
- Used as a reusable pulse-width/run monitor in front of control logic.

Parameters:
- CNT_W, 3, width of the count and run-length outputs; legal range 2..16.
- THRESH, 5, count value that triggers hit_o; legal range 1..2^CNT_W-1. Out-of-range values are an elaboration-time error.
- WRAP, 0, overflow mode. 0 = saturate at 2^CNT_W-1. 1 = wrap to 0.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- in_i  input  1  monitored signal, sampled each rising edge.
- clear_i  input  1  synchronous abort of the current run; lower priority than reset_i.
- count_o  output  CNT_W  live length of the current run.
- state_o  output  2  current state: 00 IDLE, 01 RUN, 10 DONE.
- hit_o  output  1  one-cycle pulse when count_o first reaches THRESH within a run.
- run_len_o  output  CNT_W  length of the last completed run; held until the next completion.
- valid_o  output  1  one-cycle strobe; run_len_o is updated in the same cycle.
- overflow_o  output  1  sticky per run: the run exceeded 2^CNT_W-1.

Behaviour:
- Reset and clock: the clock is clk_i; reset_i is synchronous and active-high. While reset_i is sampled 1: state IDLE, count_o=0, run_len_o=0, hit_o=0, valid_o=0, overflow_o=0. All outputs are registered.
- Priority: reset_i > clear_i > normal operation.
- IDLE:
  - in_i=1 -> RUN, count_o=1 (visible in the cycle after the sampling edge).
  - in_i=0 -> stay in IDLE, count_o=0.
- RUN, in_i=1:
  - count_o is incremented.
  - At max with WRAP=0: count_o holds at 2^CNT_W-1 and overflow_o=1.
  - At max with WRAP=1: count_o becomes 0 and overflow_o=1.
  - overflow_o stays 1 until the run ends.
- RUN, in_i=0 -> DONE. run_len_o is loaded with the current count_o, valid_o=1 for exactly that one cycle, and count_o holds its value.
- DONE (lasts one cycle):
  - in_i=1 -> RUN, count_o=1, overflow_o=0, hit_o cleared.
  - in_i=0 -> IDLE, count_o=0, overflow_o=0.
  - A one-cycle low gap between runs is therefore legal and measured correctly.
- hit_o:
  - Asserted in the same cycle that count_o becomes THRESH.
  - At most once per run, including after a wrap, enforced by an internal armed flag that is re-armed on entry to RUN from IDLE/DONE.
  - THRESH=1: hit_o coincides with the first RUN cycle.
- clear_i=1:
  - Next state is IDLE, count_o=0, overflow_o=0.
  - No valid_o pulse; run_len_o keeps its old value.
  - The in_i sample on that edge is ignored, even if in_i=1.
- Reset mid-run: the run is discarded and run_len_o returns to 0.
- Undefined states (11) return to IDLE on the next edge.
- Latency: in_i edge -> count_o/valid_o/hit_o change exactly 1 clock later.

Test Plan (defaults CNT_W=3, THRESH=5, WRAP=0 unless stated; 100 time-unit clock):
- Basic run: reset 1 cycle, in_i=1 for 4 cycles, then 0 -> count_o 1,2,3,4; then valid_o=1 with run_len_o=4, no hit_o, overflow_o=0; then IDLE with count_o=0.
- Saturate: in_i=1 for 9 cycles -> count_o 1..7,7,7; hit_o pulse when count_o=5; overflow_o=1 from the 8th high cycle; run_len_o=7 with valid_o.
- Wrap (WRAP=1): in_i=1 for 13 cycles -> count_o 1..7,0,1..5; hit_o only once, at the first 5; run_len_o=5; overflow_o=1 until DONE.
- Back-to-back: in_i high 3 cycles, low 1 cycle, high 2 cycles -> valid_o with run_len_o=3; state DONE->RUN with count_o=1; then valid_o with run_len_o=2.
- Clear and reset: clear_i=1 together with in_i=1 at count_o=3 -> IDLE, count_o=0, no valid_o, run_len_o unchanged. Later, reset_i=1 mid-run at count_o=6 -> all outputs 0.
- THRESH=1: a single high cycle -> hit_o and count_o=1 in the same cycle; then valid_o with run_len_o=1.

Source files
------------

// File: rtl/run_length_fsm.sv
// run_length_fsm: measures consecutive-high runs on in_i with live count, threshold pulse and final length.
module run_length_fsm #(
  parameter int CNT_W  = 3,
  parameter int THRESH = 5,
  parameter int WRAP   = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] run_len_o,
  output logic             valid_o,
  output logic             overflow_o
);
  if (CNT_W < 2 || CNT_W > 16 || THRESH < 1 || THRESH > (1 << CNT_W) - 1) begin : g_bad_param
    $error("run_length_fsm: illegal CNT_W/THRESH");
  end
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] TH  = CNT_W'(THRESH);
  state_t           state;
  logic             armed;
  logic             at_max;
  logic [CNT_W-1:0] inc;
  assign at_max  = count_o == MAX;
  assign inc     = at_max ? (WRAP != 0 ? '0 : MAX) : count_o + CNT_W'(1);
  assign state_o = state;
  // armed limits hit_o to one pulse per run, even when a wrapped count passes THRESH again
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      count_o    <= '0;
      run_len_o  <= '0;
      hit_o      <= 1'b0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      armed      <= 1'b0;
    end else if (clear_i) begin
      state      <= IDLE;
      count_o    <= '0;
      hit_o      <= 1'b0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      armed      <= 1'b0;
    end else begin
      hit_o   <= 1'b0;
      valid_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state      <= in_i ? RUN : IDLE;
          count_o    <= in_i ? CNT_W'(1) : '0;
          overflow_o <= 1'b0;
          hit_o      <= in_i && (THRESH == 1);
          armed      <= in_i && (THRESH != 1);
        end
        RUN: begin
          if (in_i) begin
            count_o    <= inc;
            overflow_o <= overflow_o | at_max;
            hit_o      <= armed && (inc == TH);
            armed      <= armed && (inc != TH);
          end else begin
            state     <= DONE;
            run_len_o <= count_o;
            valid_o   <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          count_o    <= '0;
          overflow_o <= 1'b0;
          armed      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_run_length_fsm.sv
// tb_run_length_fsm: three configurations (saturate, wrap, THRESH=1) driven by one directed stimulus against a run-length model.
module tb_run_length_fsm;
  localparam int MX = 7;
  localparam int TH[3] = '{5, 5, 1};
  localparam int WR[3] = '{0, 1, 0};
  logic       clk = 1'b0;
  logic       rst, clr, din;
  logic [2:0] count[3];
  logic [1:0] state[3];
  logic       hit[3];
  logic [2:0] run_len[3];
  logic       valid[3];
  logic       ovf[3];
  int         tests = 0, fails = 0;
  int         ph[3], len[3], rl[3];
  bit         started = 0;
  always #50 clk = ~clk;
  run_length_fsm #(.CNT_W(3), .THRESH(5), .WRAP(0)) u_sat (
    .clk_i(clk), .reset_i(rst), .in_i(din), .clear_i(clr), .count_o(count[0]), .state_o(state[0]),
    .hit_o(hit[0]), .run_len_o(run_len[0]), .valid_o(valid[0]), .overflow_o(ovf[0]));
  run_length_fsm #(.CNT_W(3), .THRESH(5), .WRAP(1)) u_wrap (
    .clk_i(clk), .reset_i(rst), .in_i(din), .clear_i(clr), .count_o(count[1]), .state_o(state[1]),
    .hit_o(hit[1]), .run_len_o(run_len[1]), .valid_o(valid[1]), .overflow_o(ovf[1]));
  run_length_fsm #(.CNT_W(3), .THRESH(1), .WRAP(0)) u_th1 (
    .clk_i(clk), .reset_i(rst), .in_i(din), .clear_i(clr), .count_o(count[2]), .state_o(state[2]),
    .hit_o(hit[2]), .run_len_o(run_len[2]), .valid_o(valid[2]), .overflow_o(ovf[2]));
  function automatic int shown(int k, int l);
    return WR[k] != 0 ? l % (MX + 1) : (l > MX ? MX : l);
  endfunction
  task automatic check(input string nm, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask
  // model: ph 0 idle / 1 counting / 2 just ended; len is the true unbounded run length
  always @(posedge clk) begin
    started <= 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        ph[k] = 0; len[k] = 0; rl[k] = 0;
      end else if (clr) begin
        ph[k] = 0; len[k] = 0;
      end else if (ph[k] == 1) begin
        if (din) len[k]++;
        else begin ph[k] = 2; rl[k] = shown(k, len[k]); end
      end else begin
        ph[k] = din ? 1 : 0;
        len[k] = din ? 1 : 0;
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        check("count", k, int'(count[k]), ph[k] == 0 ? 0 : shown(k, len[k]));
        check("state", k, int'(state[k]), ph[k]);
        check("hit", k, int'(hit[k]), int'(ph[k] == 1 && len[k] == TH[k]));
        check("valid", k, int'(valid[k]), int'(ph[k] == 2));
        check("overflow", k, int'(ovf[k]), int'(ph[k] != 0 && len[k] > MX));
        check("run_len", k, int'(run_len[k]), rl[k]);
      end
    end
  end
  task automatic step(input logic r, input logic c, input logic i, input int n = 1);
    for (int j = 0; j < n; j++) begin
      rst = r; clr = c; din = i;
      @(negedge clk);
    end
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; din = 1'b0;
    step(1, 0, 0);
    check("pin_reset_count", 0, int'(count[0]), 0);
    check("pin_reset_runlen", 0, int'(run_len[0]), 0);
    step(0, 0, 1, 4);
    check("pin_basic_count", 0, int'(count[0]), 4);
    step(0, 0, 0);
    check("pin_basic_valid", 0, int'(valid[0]), 1);
    check("pin_basic_runlen", 0, int'(run_len[0]), 4);
    check("pin_basic_nohit", 0, int'(hit[0]), 0);
    step(0, 0, 0);
    check("pin_basic_idle", 0, int'(state[0]), 0);
    step(0, 0, 1, 5);
    check("pin_sat_hit", 0, int'(hit[0]), 1);
    step(0, 0, 1, 4);
    check("pin_sat_count", 0, int'(count[0]), 7);
    check("pin_sat_ovf", 0, int'(ovf[0]), 1);
    check("pin_wrap9_count", 1, int'(count[1]), 1);
    step(0, 0, 0);
    check("pin_sat_runlen", 0, int'(run_len[0]), 7);
    step(0, 0, 0);
    step(0, 0, 1, 13);
    check("pin_wrap_count", 1, int'(count[1]), 5);
    check("pin_wrap_nohit", 1, int'(hit[1]), 0);
    step(0, 0, 0);
    check("pin_wrap_runlen", 1, int'(run_len[1]), 5);
    step(0, 0, 0);
    step(0, 0, 1, 3);
    step(0, 0, 0);
    check("pin_b2b_runlen1", 0, int'(run_len[0]), 3);
    step(0, 0, 1);
    check("pin_b2b_state", 0, int'(state[0]), 1);
    check("pin_b2b_count", 0, int'(count[0]), 1);
    step(0, 0, 1);
    step(0, 0, 0);
    check("pin_b2b_runlen2", 0, int'(run_len[0]), 2);
    step(0, 0, 0);
    step(0, 0, 1, 3);
    step(0, 1, 1);
    check("pin_clear_count", 0, int'(count[0]), 0);
    check("pin_clear_novalid", 0, int'(valid[0]), 0);
    check("pin_clear_runlen", 0, int'(run_len[0]), 2);
    step(0, 0, 1, 6);
    check("pin_pre_reset_count", 0, int'(count[0]), 6);
    step(1, 0, 1);
    check("pin_reset_mid_runlen", 0, int'(run_len[0]), 0);
    check("pin_reset_mid_state", 0, int'(state[0]), 0);
    step(0, 0, 0);
    step(0, 0, 1);
    check("pin_th1_hit", 2, int'(hit[2]), 1);
    check("pin_th1_count", 2, int'(count[2]), 1);
    step(0, 0, 0);
    check("pin_th1_runlen", 2, int'(run_len[2]), 1);
    step(0, 0, 0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
